expr_eval: RTL and testbench
============================

// Module: expr_eval
// PURPOSE
//   Downstream companion of the ASCII expression recogniser: consumes the same one-char-per-cycle
//   stream (digits '0'-'9', '+', '*') and evaluates it with '*' before '+'. Tracks grammar itself,
//   outputs a running registered result plus ok/err status. Single clock domain, no memories.
// PARAMETERS
//   WIDTH  16  result/accumulator width; arithmetic is modulo 2^WIDTH
// PORTS
//   clk     in   1      clock; all state updates on rising edge
//   clr     in   1      synchronous, active-high reset
//   in      in   8      ASCII character
//   in_vld  in   1      in holds a character this cycle; low = idle cycle, nothing consumed
//   result  out  WIDTH  value of the expression up to its last accepted digit
//   ok      out  1      1 = chars consumed since clr form a complete legal expression
//   err     out  1      sticky: illegal char/sequence seen since clr
//   ovf     out  1      sticky: an add or multiply exceeded WIDTH bits since clr
// BEHAVIOUR
//   - Reset (clr=1 at edge): state=S_START, sum=0, term=0, op=ADD, result=0, ok=0, err=0, ovf=0.
//     clr beats in_vld in the same cycle; that char is dropped. clr mid-expression discards all.
//   - Char accepted at edge k when in_vld=1 && clr=0; outputs reflect it after edge k (1-cycle latency).
//   - FSM: S_START (expect digit) -digit-> S_NUM; S_NUM -op-> S_OP; S_OP -digit-> S_NUM;
//     anything else (op in S_START/S_OP, digit in S_NUM, non-grammar char) -> S_ERR.
//     S_ERR absorbing until clr. ok = (state==S_NUM) && !err, registered.
//   - Digit d (in-8'h30): op==MUL -> term <= term*d; else term <= d. result <= sum + new term.
//   - '+': sum <= sum + term, op <= ADD. '*': op <= MUL. result unchanged on operators.
//   - Width: products formed at WIDTH+4 bits, sums at WIDTH+1; any nonzero bit above WIDTH sets ovf;
//     stored values truncated to WIDTH bits.
//   - On entry to S_ERR: err<=1, ok<=0, result/sum/term frozen at pre-error values.
//   - Multi-digit numbers not supported (matches recogniser grammar: "12" is illegal).
//   - Expression ending in an operator: ok=0, result = value through last digit.
// CONFIGURATION
//   EXPR_EVAL_MINUS_EN defined: '-' accepted as binary operator, same grammar slot as '+';
//     on '-': sum <= sum + term, op <= SUB; next digit: term <= -d (two's complement);
//     '*' after a SUB term keeps the sign (term*d). Subtraction wraps, never sets ovf.
//   Not defined: '-' is an illegal char -> S_ERR. No other behaviour differs.
// TESTING
//   1. clr; "1","+","2" back-to-back -> after 3rd edge result=3, ok=1, err=0, ovf=0.
//   2. clr; "1","*","3","+","5" -> after "3": result=3 ok=1; after "+": ok=0 result=3; end result=8 ok=1.
//   3. clr; "1","+","+","2" -> after 2nd '+': err=1 ok=0 result=1; stays so after "2"; clr -> all outputs 0.
//   4. clr; "2","3" -> err=1, result=2; also "+2" from reset -> err=1 on first edge, result=0.
//   5. WIDTH=8: "9",idle x3 (in_vld=0),"*","9","*","9","*","9" -> result=8'hA1 (6561 mod 256), ovf=1,
//      ok=1; idle cycles change nothing.
//   6. "3","-","5": with EXPR_EVAL_MINUS_EN result=16'hFFFE ok=1; without, err=1 after '-';
//      clr asserted with in_vld=1 "7" -> char dropped, result=0.

Source files
------------

// File: rtl/expr_eval.sv
// expr_eval: evaluates a one-char-per-cycle digit/'+'/'*' stream, '*' before '+'.
// Optional EXPR_EVAL_MINUS_EN adds binary '-' in the same grammar slot as '+'.
module expr_eval #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [7:0]       in,
   input  logic             in_vld,
   output logic [WIDTH-1:0] result,
   output logic             ok,
   output logic             err,
   output logic             ovf
);

   typedef enum logic [1:0] {
      S_START,
      S_NUM,
      S_OP,
      S_ERR
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD,
      OP_SUB,
      OP_MUL
   } op_t;

   state_t           r_state;
   op_t              r_op;
   logic [WIDTH-1:0] r_sum;
   logic [WIDTH-1:0] r_term;
   logic             r_neg;

   logic             w_is_dig;
   logic             w_is_add;
   logic             w_is_mul;
   logic             w_is_sub;
   logic [3:0]       w_d;
   logic [WIDTH-1:0] w_dig_ext;
   logic [WIDTH+3:0] w_prod;
   logic [WIDTH-1:0] w_term_nxt;
   logic             w_neg_nxt;
   logic [WIDTH:0]   w_res_sum;
   logic [WIDTH:0]   w_acc_sum;
   logic             w_dig_ovf;
   logic             w_op_ovf;
   logic             w_dig_ok;
   logic             w_op_ok;

   assign w_is_dig  = (in >= 8'h30) && (in <= 8'h39);
   assign w_is_add  = (in == 8'h2B);
   assign w_is_mul  = (in == 8'h2A);
`ifdef EXPR_EVAL_MINUS_EN
   assign w_is_sub  = (in == 8'h2D);
`else
   assign w_is_sub  = 1'b0;
`endif
   assign w_d       = in[3:0];
   assign w_dig_ext = {{(WIDTH-4){1'b0}}, w_d};
   assign w_prod    = {4'b0, r_term} * {{WIDTH{1'b0}}, w_d};

   always_comb begin
      w_term_nxt = w_dig_ext;
      w_neg_nxt  = 1'b0;
      if (r_op == OP_MUL) begin
         w_term_nxt = w_prod[WIDTH-1:0];
         w_neg_nxt  = r_neg;
      end else if (r_op == OP_SUB) begin
         w_term_nxt = '0 - w_dig_ext;
         w_neg_nxt  = 1'b1;
      end
   end

   assign w_res_sum = {1'b0, r_sum} + {1'b0, w_term_nxt};
   assign w_acc_sum = {1'b0, r_sum} + {1'b0, r_term};

   // negative terms wrap silently; only unsigned growth counts as overflow
   assign w_dig_ovf = ((r_op == OP_MUL) && !r_neg && (|w_prod[WIDTH+3:WIDTH]))
                    || (!w_neg_nxt && w_res_sum[WIDTH]);
   assign w_op_ovf  = !r_neg && w_acc_sum[WIDTH];

   assign w_dig_ok = w_is_dig && ((r_state == S_START) || (r_state == S_OP));
   assign w_op_ok  = (w_is_add || w_is_mul || w_is_sub) && (r_state == S_NUM);

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= S_START;
         r_op    <= OP_ADD;
         r_sum   <= '0;
         r_term  <= '0;
         r_neg   <= 1'b0;
         result  <= '0;
         ok      <= 1'b0;
         err     <= 1'b0;
         ovf     <= 1'b0;
      end else if (in_vld && (r_state != S_ERR)) begin
         unique case (1'b1)
            w_dig_ok: begin
               r_state <= S_NUM;
               r_term  <= w_term_nxt;
               r_neg   <= w_neg_nxt;
               result  <= w_res_sum[WIDTH-1:0];
               ok      <= 1'b1;
               ovf     <= ovf | w_dig_ovf;
            end
            w_op_ok: begin
               r_state <= S_OP;
               ok      <= 1'b0;
               if (w_is_mul) begin
                  r_op <= OP_MUL;
               end else begin
                  r_sum <= w_acc_sum[WIDTH-1:0];
                  r_op  <= w_is_sub ? OP_SUB : OP_ADD;
                  ovf   <= ovf | w_op_ovf;
               end
            end
            default: begin
               r_state <= S_ERR;
               ok      <= 1'b0;
               err     <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_expr_eval.sv
// Bench for expr_eval: 16-bit and 8-bit instances share one directed stream,
// checked each cycle against a whole-stream re-evaluation model plus literals.
module tb_expr_eval;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [7:0]  in = 8'h00;
   logic        in_vld = 1'b0;
   logic [15:0] r16;
   logic        ok16, err16, ovf16;
   logic [7:0]  r8;
   logic        ok8, err8, ovf8;

   int  checks = 0;
   int  errors = 0;
   bit  armed = 1'b0;
   byte q[$];

`ifdef EXPR_EVAL_MINUS_EN
   localparam bit MINUS = 1'b1;
`else
   localparam bit MINUS = 1'b0;
`endif

   expr_eval #(.WIDTH(16)) u16 (
      .clk(clk), .clr(clr), .in(in), .in_vld(in_vld),
      .result(r16), .ok(ok16), .err(err16), .ovf(ovf16)
   );

   expr_eval #(.WIDTH(8)) u8 (
      .clk(clk), .clr(clr), .in(in), .in_vld(in_vld),
      .result(r8), .ok(ok8), .err(err8), .ovf(ovf8)
   );

   always #5 clk = ~clk;

   // record every character the spec says is consumed
   always @(posedge clk) begin
      if (clr) q.delete();
      else if (in_vld) q.push_back(in);
   end

   // re-evaluate the whole accepted stream from scratch
   function automatic void eval(input int w, output longint res,
                                output bit ok, output bit er,
                                output bit ov);
      longint mask, sum, term, p, s;
      bit mul, neg, want_d;
      byte c;
      mask = (longint'(1) << w) - 1;
      sum = 0; term = 0; res = 0;
      mul = 0; neg = 0; want_d = 1;
      er = 0; ov = 0;
      foreach (q[i]) begin
         c = q[i];
         if (c >= "0" && c <= "9") begin
            if (!want_d) begin er = 1; break; end
            if (mul) begin
               p = term * longint'(c - "0");
               if (!neg && p > mask) ov = 1;
               term = p & mask;
            end else begin
               neg = neg;
               term = neg ? ((-longint'(c - "0")) & mask)
                          : longint'(c - "0");
            end
            s = sum + term;
            if (!neg && s > mask) ov = 1;
            res = s & mask;
            want_d = 0;
         end else if (c == "+" || c == "*" || (MINUS && c == "-")) begin
            if (want_d) begin er = 1; break; end
            if (c == "*") begin
               mul = 1;
            end else begin
               s = sum + term;
               if (!neg && s > mask) ov = 1;
               sum = s & mask;
               mul = 0;
               neg = (c == "-");
            end
            want_d = 1;
         end else begin
            er = 1;
            break;
         end
      end
      ok = !er && !want_d;
   endfunction

   always @(negedge clk) begin
      longint er_; bit eok, eerr, eovf;
      if (armed) begin
         eval(16, er_, eok, eerr, eovf);
         checks++;
         if (longint'(r16) != er_ || ok16 != eok || err16 != eerr || ovf16 != eovf) begin
            errors++;
            $display("FAIL model16 t=%0t got r=%h ok=%b err=%b ovf=%b want r=%h ok=%b err=%b ovf=%b",
                     $time, r16, ok16, err16, ovf16, er_[15:0], eok, eerr, eovf);
         end
         eval(8, er_, eok, eerr, eovf);
         checks++;
         if (longint'(r8) != er_ || ok8 != eok || err8 != eerr || ovf8 != eovf) begin
            errors++;
            $display("FAIL model8 t=%0t got r=%h ok=%b err=%b ovf=%b want r=%h ok=%b err=%b ovf=%b",
                     $time, r8, ok8, err8, ovf8, er_[7:0], eok, eerr, eovf);
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] got,
                      input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, exp);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] res,
                        input bit eok, input bit eerr, input bit eovf);
      chk({name, ".res"}, r16, res);
      chk({name, ".ok"}, {15'b0, ok16}, {15'b0, eok});
      chk({name, ".err"}, {15'b0, err16}, {15'b0, eerr});
      chk({name, ".ovf"}, {15'b0, ovf16}, {15'b0, eovf});
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
   endtask

   task automatic send(input byte c);
      in = c;
      in_vld = 1'b1;
      @(posedge clk); #1;
      in_vld = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic sends(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   initial begin
      @(posedge clk); #1;
      do_clr();
      armed = 1'b1;
      chk16("reset", 16'h0, 0, 0, 0);

      send("1"); send("+"); send("2");
      chk16("t1", 16'd3, 1, 0, 0);

      do_clr();
      sends("1*3");
      chk16("t2a", 16'd3, 1, 0, 0);
      send("+");
      chk16("t2b", 16'd3, 0, 0, 0);
      send("5");
      chk16("t2c", 16'd8, 1, 0, 0);

      do_clr();
      sends("1++");
      chk16("t3a", 16'd1, 0, 1, 0);
      send("2");
      chk16("t3b", 16'd1, 0, 1, 0);
      do_clr();
      chk16("t3c", 16'd0, 0, 0, 0);

      do_clr();
      sends("23");
      chk16("t4a", 16'd2, 0, 1, 0);
      do_clr();
      send("+");
      chk16("t4b", 16'd0, 0, 1, 0);
      send("2");
      chk16("t4c", 16'd0, 0, 1, 0);

      do_clr();
      send("9");
      idle(3);
      chk("t5.idle8", {8'h0, r8}, 16'h0009);
      sends("*9*9*9");
      chk("t5.res8", {8'h0, r8}, 16'h00A1);
      chk("t5.ovf8", {15'b0, ovf8}, 16'h1);
      chk("t5.ok8", {15'b0, ok8}, 16'h1);
      chk16("t5.w16", 16'h19A1, 1, 0, 0);

      do_clr();
      sends("9*9*9*9*9*9");
      chk16("mulovf", 16'h1BF1, 1, 0, 1);

      do_clr();
      sends("9*9*9*9*9+9*9*9*9*9");
      chk16("addovf", 16'hCD52, 1, 0, 1);

      do_clr();
      sends("4+a");
      chk16("badchar", 16'd4, 0, 1, 0);

      do_clr();
      sends("3-");
      if (MINUS) chk16("t6a", 16'd3, 0, 0, 0);
      else       chk16("t6a", 16'd3, 0, 1, 0);
      send("5");
      if (MINUS) chk16("t6b", 16'hFFFE, 1, 0, 0);
      else       chk16("t6b", 16'd3, 0, 1, 0);

      in = "7";
      in_vld = 1'b1;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      in_vld = 1'b0;
      chk16("clrdrop", 16'd0, 0, 0, 0);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
